// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Instruction fetch stage. Holds the PC, issues one read at a  |
// |               time to the instruction memory port and buffers returned     |
// |               words in a DEPTH-entry prefetch FIFO that decode pops.       |
// |               Redirects flush the FIFO; halt stops fetching (sticky).      |
// |               Optional macro FETCH_STATS_EN adds fetch_count/stall_count.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        deq,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic        fetch_idle
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int c_ptrW = $clog2(DEPTH);
  localparam int c_cntW = c_ptrW + 1;
  localparam logic [c_cntW-1:0] c_lastCnt = c_cntW'(DEPTH - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    FULL = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [31:0]         r_pc;
  logic [c_ptrW-1:0]   r_head;
  logic [c_ptrW-1:0]   r_tail;
  logic [c_cntW-1:0]   r_count;
  logic [31:0]         r_instrMem [DEPTH];
  logic [31:0]         r_pcMem    [DEPTH];
  logic                w_enq;
  logic                w_deq;

  // A redirect discards both the returning word and any decode pop this cycle.
  assign w_enq = imemREN && ihit && !redirect;
  assign w_deq = deq && (r_count != '0) && !redirect;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_nextState;
  end

  // Next-state and request/idle outputs; halt outranks redirect and FIFO flow.
  always_comb begin
    w_nextState = r_state;
    imemREN     = 1'b0;
    fetch_idle  = 1'b0;
    if (halt || r_state == HALT) begin
      w_nextState = HALT;
    end else if (redirect) begin
      w_nextState = RUN;
    end else begin
      case (r_state)
        RUN:     if (w_enq && !w_deq && r_count == c_lastCnt) w_nextState = FULL;
        FULL:    if (w_deq) w_nextState = RUN;
        default: w_nextState = r_state;
      endcase
    end
    imemREN    = (r_state == RUN);
    fetch_idle = (r_state == HALT) && (r_count == '0);
  end

  // Program counter: redirect target is forced word aligned; advance on accepted read.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         r_pc <= PC_INIT;
    else if (redirect) r_pc <= redirect_pc & 32'hFFFF_FFFC;
    else if (w_enq)    r_pc <= r_pc + 32'd4;
  end

  // Prefetch ring buffer: storage, wrapping pointers and occupancy count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instrMem[i] <= '0;
        r_pcMem[i]    <= '0;
      end
    end else if (redirect) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_instrMem[r_tail] <= imemload;
        r_pcMem[r_tail]    <= r_pc;
        r_tail             <= r_tail + c_ptrW'(1);
      end
      if (w_deq) r_head <= r_head + c_ptrW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cntW'(1);
        2'b01:   r_count <= r_count - c_cntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imemaddr = r_pc;
  assign valid    = (r_count != '0);
  assign instr    = r_instrMem[r_head];
  assign instr_pc = r_pcMem[r_head];
  assign opcode   = instr[31:26];

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetchCount;
  logic [31:0] r_stallCount;

  // Accepted fetches and cycles spent waiting on the memory.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetchCount <= '0;
      r_stallCount <= '0;
    end else begin
      if (w_enq)             r_fetchCount <= r_fetchCount + 32'd1;
      if (imemREN && !ihit)  r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign fetch_count = r_fetchCount;
  assign stall_count = r_stallCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Self-checking bench for instr_fetch_unit: directed scenarios |
// |               followed by random traffic against a queue-based model.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic        fetch_idle;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instr_fetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .imemload    (imemload),
    .ihit        (ihit),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .deq         (deq),
    .valid       (valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .opcode      (opcode),
    .fetch_idle  (fetch_idle)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int nPass   = 0;
  int nChecks = 0;

  // Reference model: a queue of (word, address) pairs plus the fetch address.
  logic [31:0] mPc;
  logic        mHalted;
  logic [31:0] qW[$];
  logic [31:0] qP[$];
  logic [31:0] mFetch;
  logic [31:0] mStall;

  function automatic void modelReset();
    mPc     = PC_INIT;
    mHalted = 1'b0;
    qW.delete();
    qP.delete();
    mFetch  = '0;
    mStall  = '0;
  endfunction

  function automatic logic modelRen();
    return !mHalted && (qW.size() < DEPTH);
  endfunction

  function automatic void modelStep();
    logic ren;
    ren = modelRen();
    if (ren && !ihit) mStall = mStall + 32'd1;
    if (redirect) begin
      qW.delete();
      qP.delete();
      mPc = redirect_pc & ~32'd3;
    end else begin
      if (deq && qW.size() > 0) begin
        void'(qW.pop_front());
        void'(qP.pop_front());
      end
      if (ren && ihit) begin
        qW.push_back(imemload);
        qP.push_back(mPc);
        mPc    = mPc + 32'd4;
        mFetch = mFetch + 32'd1;
      end
    end
    if (halt) mHalted = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".ren"},   32'(imemREN), 32'(modelRen()));
    chk({tag, ".addr"},  imemaddr, mPc);
    chk({tag, ".valid"}, 32'(valid), 32'(qW.size() != 0));
    chk({tag, ".idle"},  32'(fetch_idle), 32'(mHalted && qW.size() == 0));
    if (qW.size() != 0) begin
      chk({tag, ".instr"},  instr, qW[0]);
      chk({tag, ".ipc"},    instr_pc, qP[0]);
      chk({tag, ".opcode"}, 32'(opcode), 32'(qW[0][31:26]));
    end
`ifdef FETCH_STATS_EN
    chk({tag, ".fcnt"}, fetch_count, mFetch);
    chk({tag, ".scnt"}, stall_count, mStall);
`endif
  endtask

  // Called at a falling edge: apply inputs, advance one clock, check at the next falling edge.
  task automatic drive(input logic ih, input logic dq, input logic rd, input logic [31:0] rpc,
                       input logic hl, input string tag);
    ihit        = ih;
    deq         = dq;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    imemload    = $urandom;
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
    checkAll(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic asyncReset(input string tag);
    ihit = 1'b0; deq = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    modelReset();
    chk({tag, ".valid"},  32'(valid), 32'd0);
    chk({tag, ".instr"},  instr, 32'd0);
    chk({tag, ".ipc"},    instr_pc, 32'd0);
    chk({tag, ".opcode"}, 32'(opcode), 32'd0);
    chk({tag, ".idle"},   32'(fetch_idle), 32'd0);
    chk({tag, ".addr"},   imemaddr, PC_INIT);
`ifdef FETCH_STATS_EN
    chk({tag, ".fcnt"}, fetch_count, 32'd0);
    chk({tag, ".scnt"}, stall_count, 32'd0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checkAll({tag, ".post"});
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
    redirect_pc = '0; halt = 1'b0; imemload = '0;
    modelReset();
    repeat (2) @(negedge CLK);
    chk("rst.valid",  32'(valid), 32'd0);
    chk("rst.instr",  instr, 32'd0);
    chk("rst.ipc",    instr_pc, 32'd0);
    chk("rst.opcode", 32'(opcode), 32'd0);
    chk("rst.idle",   32'(fetch_idle), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rel.ren",  32'(imemREN), 32'd1);
    chk("rel.addr", imemaddr, PC_INIT);

    // Fill to full with a zero-wait memory, then hold while ihit is ignored.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "fill");
    chk("full.ren",   32'(imemREN), 32'd0);
    chk("full.valid", 32'(valid), 32'd1);
    chk("full.ipc",   instr_pc, 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "full_hold");

    // Redirect flush with an unaligned target.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b0, "redir");
    chk("redir.valid", 32'(valid), 32'd0);
    chk("redir.addr",  imemaddr, 32'h0000_0100);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "after_redir");
    chk("after_redir.ipc", instr_pc, 32'h0000_0100);

    // Returning word coinciding with a redirect is dropped, as is a same-cycle deq.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, "hit_redir");
    chk("hit_redir.valid", 32'(valid), 32'd0);
    chk("hit_redir.addr",  imemaddr, 32'h0000_0200);

    // Streaming: one instruction per cycle, occupancy stays at one.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, '0, 1'b0, "stream");

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, "wrap_redir");
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "wrap");
    chk("wrap.addr", imemaddr, 32'h0000_0000);
    chk("wrap.ipc",  instr_pc, 32'hFFFF_FFFC);

    // Halt with three entries queued, then drain.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "q2");
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "q3");
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, "halt");
    chk("halt.ren", 32'(imemREN), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0, 1'b0, "drain");
    chk("drain.idle", 32'(fetch_idle), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, "halt_redir");
    chk("halt_redir.ren", 32'(imemREN), 32'd0);

    // Reset while a read is outstanding.
    asyncReset("rst2");
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "mw_fill");
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, "mw_fill");
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, "mw_wait");
    asyncReset("rst_midwait");

    // Random traffic with occasional redirects, rare halts and periodic resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) asyncReset("rst_rand");
      else drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 15) == 0), $urandom,
                 1'($urandom_range(0, 199) == 0), "rand");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
